cpu_mem_responder: RTL and testbench

- Bus-slave end of the CPU `cpu_mem_*` request/ready interface: a word-organised on-chip RAM that answers CPU requests after a programmable number of wait states.
- Replaces the zero-latency, always-ready memory model used in CPU benches. Lets the barrel-threaded core be exercised with real stall behaviour, and gives the FPGA top a synthesizable instruction/data store.
- Includes a side load port so a host or bench can preload a program without going through the CPU.

---
 rtl/cpu_mem_responder_if.sv | 26 ++
 rtl/cpu_mem_responder.sv | 97 +++++++++
 tb/tb_cpu_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_if.sv
// rtl/cpu_mem_responder_if.sv - CPU request/ready memory bus between core and memory responder
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

interface cpu_mem_responder_if;
    logic               cpu_mem_req;
    logic               cpu_mem_we;
    logic [`ADDR_W-1:0] cpu_mem_addr;
    logic [`XLEN-1:0]   cpu_mem_wdata;
    logic [`XLEN-1:0]   cpu_mem_rdata;
    logic               cpu_mem_ready;

    modport master (
        output cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
        input  cpu_mem_rdata, cpu_mem_ready
    );

    modport slave (
        input  cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
        output cpu_mem_rdata, cpu_mem_ready
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - word RAM answering CPU requests after programmable wait states
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

module cpu_mem_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_mem_responder_if.slave   bus,
    input  logic                 load_we,
    input  logic [AW-1:0]        load_addr,
    input  logic [`XLEN-1:0]     load_wdata,
    output logic                 mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [`ADDR_W-1:0] LIMIT = DEPTH * 4;

    state_t             state, state_next;
    logic [3:0]         cnt;
    logic               lat_we;
    logic [`ADDR_W-1:0] lat_addr;
    logic [`XLEN-1:0]   lat_wdata;
    logic               commit;
    logic               in_range;
    logic [AW-1:0]      idx;

    logic [`XLEN-1:0]   mem [DEPTH];

    assign commit   = (state == S_WAIT) && (cnt == 4'd0);
    assign in_range = lat_addr < LIMIT;
    assign idx      = lat_addr[AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RESP always returns to IDLE without looking at req, so a held req cannot double-issue.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.cpu_mem_req) state_next = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt               <= 4'd0;
            lat_we            <= 1'b0;
            lat_addr          <= '0;
            lat_wdata         <= '0;
            bus.cpu_mem_ready <= 1'b0;
            bus.cpu_mem_rdata <= '0;
            mem_err           <= 1'b0;
        end else begin
            bus.cpu_mem_ready <= commit;
            mem_err           <= commit && !in_range;
            if (state == S_IDLE && bus.cpu_mem_req) begin
                lat_we    <= bus.cpu_mem_we;
                lat_addr  <= bus.cpu_mem_addr;
                lat_wdata <= bus.cpu_mem_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !lat_we) begin
                bus.cpu_mem_rdata <= in_range ? mem[idx] : '0;
            end
        end
    end

    // The load port is assigned last so it overrides a CPU write to the same word.
    always_ff @(posedge clk) begin
        if (commit && lat_we && in_range) begin
            mem[idx] <= lat_wdata;
        end
        if (load_we) begin
            mem[load_addr] <= load_wdata;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - randomized self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_we = 1'b0;
    logic [8:0]  load_addr = '0;
    logic [31:0] load_wdata = '0;
    logic        mem_err;

    cpu_mem_responder_if bus ();

    cpu_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_wdata (load_wdata),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_wdata = d;
        @(negedge clk);
        load_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // One CPU access from an idle bus; optionally a load strobe lands on the commit edge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic coll, input logic [8:0] caddr, input logic [31:0] cdata);
        int          n;
        logic        got;
        logic        inr;
        logic [8:0]  idx;
        logic [31:0] exp_rd;
        inr = addr < DEPTH * 4;
        idx = addr[10:2];
        @(negedge clk);
        bus.cpu_mem_req = 1'b1; bus.cpu_mem_we = we;
        bus.cpu_mem_addr = addr; bus.cpu_mem_wdata = wd;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            load_we = 1'b0;
            if (coll && n == LAT) begin
                load_we = 1'b1; load_addr = caddr; load_wdata = cdata;
            end
            if (bus.cpu_mem_ready) got = 1'b1;
            // Garbage on the request fields while waiting must be ignored.
            if (!got) begin
                bus.cpu_mem_we = ~we; bus.cpu_mem_addr = $urandom; bus.cpu_mem_wdata = $urandom;
            end
        end
        load_we = 1'b0;
        check("latency", 32'(n), 32'(LAT + 1));
        exp_rd = we ? last_rd : (inr ? ref_mem[idx] : 32'h0);
        if (we && inr) ref_mem[idx] = wd;
        if (coll) ref_mem[caddr] = cdata;
        last_rd = exp_rd;
        check("rdata", bus.cpu_mem_rdata, exp_rd);
        check("mem_err", 32'(mem_err), 32'(!inr));
        bus.cpu_mem_req = 1'b0;
        @(negedge clk);
        check("ready_pulse", 32'(bus.cpu_mem_ready), 32'h0);
        check("err_pulse", 32'(mem_err), 32'h0);
        check("rdata_hold", bus.cpu_mem_rdata, last_rd);
    endtask

    initial begin
        int          cnt_r;
        int          first;
        int          last;
        logic        gap_ok;
        logic        we;
        logic        coll;
        logic [8:0]  w;
        logic [31:0] a;

        bus.cpu_mem_req = 1'b0; bus.cpu_mem_we = 1'b0;
        bus.cpu_mem_addr = '0; bus.cpu_mem_wdata = '0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_we = 1'b1; load_addr = 9'(i); load_wdata = $urandom;
            ref_mem[i] = load_wdata;
        end
        @(negedge clk);
        load_we = 1'b0;
        check("rst_ready", 32'(bus.cpu_mem_ready), 32'h0);
        check("rst_rdata", bus.cpu_mem_rdata, 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        rst = 1'b0;

        load(9'd5, 32'hDEADBEEF);
        access(1'b0, 32'h14, 32'h0, 1'b0, 9'd0, 32'h0);
        check("read_w5", last_rd, 32'hDEADBEEF);

        access(1'b1, 32'h40, 32'h12345678, 1'b0, 9'd0, 32'h0);
        access(1'b0, 32'h40, 32'h0, 1'b0, 9'd0, 32'h0);
        check("readback_40", last_rd, 32'h12345678);

        @(negedge clk);
        bus.cpu_mem_req = 1'b1; bus.cpu_mem_we = 1'b0; bus.cpu_mem_addr = 32'h14;
        cnt_r = 0; first = -1; last = -1; gap_ok = 1'b1;
        for (int n = 1; n <= 3 * (LAT + 2); n++) begin
            @(negedge clk);
            if (bus.cpu_mem_ready) begin
                if (first < 0) first = n;
                else if (n - last != LAT + 2) gap_ok = 1'b0;
                last = n;
                cnt_r++;
            end
        end
        bus.cpu_mem_req = 1'b0;
        check("b2b_count", 32'(cnt_r), 32'd3);
        check("b2b_first", 32'(first), 32'(LAT + 1));
        check("b2b_gap", 32'(gap_ok), 32'h1);
        check("b2b_rdata", bus.cpu_mem_rdata, ref_mem[5]);
        last_rd = ref_mem[5];

        access(1'b0, 32'h800, 32'h0, 1'b0, 9'd0, 32'h0);
        access(1'b1, 32'h800, 32'hFFFFFFFF, 1'b0, 9'd0, 32'h0);

        access(1'b1, 32'h0C, 32'hAAAA, 1'b1, 9'd3, 32'h5555);
        access(1'b0, 32'h0C, 32'h0, 1'b0, 9'd0, 32'h0);
        check("coll_wr", last_rd, 32'h5555);
        access(1'b0, 32'h0C, 32'h0, 1'b1, 9'd3, 32'h1234);
        check("coll_rd_old", last_rd, 32'h5555);
        access(1'b0, 32'h0C, 32'h0, 1'b0, 9'd0, 32'h0);
        check("coll_rd_new", last_rd, 32'h1234);

        load(9'd9, 32'h11);
        @(negedge clk);
        bus.cpu_mem_req = 1'b1; bus.cpu_mem_we = 1'b1;
        bus.cpu_mem_addr = 32'h24; bus.cpu_mem_wdata = 32'h77;
        @(negedge clk);
        rst = 1'b1;
        bus.cpu_mem_we = 1'b0;
        for (int n = 0; n < LAT + 2; n++) begin
            @(negedge clk);
            check("rstmid_ready", 32'(bus.cpu_mem_ready), 32'h0);
            check("rstmid_rdata", bus.cpu_mem_rdata, 32'h0);
        end
        rst = 1'b0;
        cnt_r = 0;
        for (int n = 1; n <= LAT + 1; n++) begin
            @(negedge clk);
            if (bus.cpu_mem_ready) cnt_r = n;
        end
        bus.cpu_mem_req = 1'b0;
        check("rst_recapture", 32'(cnt_r), 32'(LAT + 1));
        check("rst_w9", bus.cpu_mem_rdata, 32'h11);
        last_rd = 32'h11;
        @(negedge clk);

        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom_range(0, 1));
            w  = 9'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h800;
            else a = {21'h0, w, 2'($urandom_range(0, 3))};
            coll = ($urandom_range(0, 3) == 0);
            access(we, a, $urandom, coll,
                   $urandom_range(0, 1) ? a[10:2] : 9'($urandom_range(0, DEPTH - 1)), $urandom);
        end

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 32'(i * 4), 32'h0, 1'b0, 9'd0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
